// File: rtl/serial_pkg.sv
// serial_pkg: shared defaults and FSM state encoding for the serial frame receiver.
//   DEF_WIDTH   - default bits per received word
//   DEF_DEPTH   - default output FIFO depth
//   DEF_TIMEOUT - default CLK cycles of RCLK silence before a partial word is dropped
//   ST_IDLE / ST_RECV - receiver FSM state codes
package serial_pkg;

   localparam int unsigned DEF_WIDTH   = 8;
   localparam int unsigned DEF_DEPTH   = 4;
   localparam int unsigned DEF_TIMEOUT = 1000000;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RECV = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word fall-through FIFO with a registered head word.
//   clk, reset        - clock, synchronous active-high reset
//   push, push_data   - write request and word
//   pop               - read request (ignored while empty)
//   full, empty       - registered occupancy flags
//   valid             - registered non-empty flag for the consumer
//   level             - registered occupancy 0..DEPTH
//   head              - registered word at the read pointer
module sync_fifo
   import serial_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned DEPTH = DEF_DEPTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic                       full,
   output logic                       empty,
   output logic                       valid,
   output logic [$clog2(DEPTH+1)-1:0] level,
   output logic [WIDTH-1:0]           head
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_ptr_nxt;
   logic [LW-1:0]    count_nxt;
   logic [WIDTH-1:0] head_nxt;
   logic             pop_ok;
   logic             push_ok;

   // A push into a full FIFO is only taken when a pop frees a slot in the same cycle.
   always_comb begin
      pop_ok     = pop & ~empty;
      push_ok    = push & (~full | pop_ok);
      rd_ptr_nxt = rd_ptr + AW'(pop_ok);
      count_nxt  = level + LW'(push_ok) - LW'(pop_ok);
      head_nxt   = head;
      // The next head is the incoming word when it lands exactly at the new read slot.
      if (count_nxt != '0) begin
         if (push_ok && (wr_ptr == rd_ptr_nxt)) begin
            head_nxt = push_data;
         end else begin
            head_nxt = mem[rd_ptr_nxt];
         end
      end
   end

   // Storage array, no reset needed.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers, occupancy and head register.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
         valid  <= 1'b0;
         head   <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push_ok);
         rd_ptr <= rd_ptr_nxt;
         level  <= count_nxt;
         full   <= (count_nxt == LW'(DEPTH));
         empty  <= (count_nxt == '0);
         valid  <= (count_nxt != '0);
         head   <= head_nxt;
      end
   end

endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: oversampling receiver for a sender-clocked serial stream.
//   CLK, RESET   - system clock, synchronous active-high reset
//   RCLK, RDATA  - asynchronous serial clock/data from the sender
//   OUT_DATA     - FIFO head word
//   OUT_VALID    - FIFO non-empty
//   OUT_READY    - consumer accepts the head word
//   LEVEL        - FIFO occupancy
//   FRAME_ERR    - one-cycle pulse when a partial word is abandoned on timeout
//   OVERFLOW     - sticky flag, a completed word was dropped on a full FIFO
module serial_frame_rx
   import serial_pkg::*;
#(
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned DEPTH     = DEF_DEPTH,
   parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
   parameter int unsigned MSB_FIRST = 0
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic                       RCLK,
   input  logic                       RDATA,
   output logic [WIDTH-1:0]           OUT_DATA,
   output logic                       OUT_VALID,
   input  logic                       OUT_READY,
   output logic [$clog2(DEPTH+1)-1:0] LEVEL,
   output logic                       FRAME_ERR,
   output logic                       OVERFLOW
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam int unsigned IW = $clog2(TIMEOUT + 1);

   logic             rclk_s1, rclk_s2, rclk_prev;
   logic             rdata_s1, rdata_s2;
   logic             bit_stb;
   logic [0:0]       state, state_nxt;
   logic [CW-1:0]    bit_cnt, cnt_nxt;
   logic [CW-1:0]    bit_idx;
   logic [IW-1:0]    idle_cnt, idle_nxt;
   logic [WIDTH-1:0] word, word_nxt;
   logic             ferr_nxt;
   logic             push_c;
   logic             fifo_full, fifo_empty;

   // Two-flop synchronizers; RDATA gets the same depth so it lines up with the RCLK edge.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         rclk_s1   <= 1'b0;
         rclk_s2   <= 1'b0;
         rclk_prev <= 1'b0;
         rdata_s1  <= 1'b0;
         rdata_s2  <= 1'b0;
      end else begin
         rclk_s1   <= RCLK;
         rclk_s2   <= rclk_s1;
         rclk_prev <= rclk_s2;
         rdata_s1  <= RDATA;
         rdata_s2  <= rdata_s1;
      end
   end

   assign bit_stb = rclk_s2 & ~rclk_prev;
   assign bit_idx = (MSB_FIRST != 0) ? (CW'(WIDTH - 1) - bit_cnt) : bit_cnt;

   // FSM state, bit counter, idle counter, assembly word and error pulse.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= ST_IDLE;
         bit_cnt   <= '0;
         idle_cnt  <= '0;
         word      <= '0;
         FRAME_ERR <= 1'b0;
      end else begin
         state     <= state_nxt;
         bit_cnt   <= cnt_nxt;
         idle_cnt  <= idle_nxt;
         word      <= word_nxt;
         FRAME_ERR <= ferr_nxt;
      end
   end

   // Next-state logic: bit capture, word completion and timeout abort.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = bit_cnt;
      idle_nxt  = idle_cnt;
      word_nxt  = word;
      ferr_nxt  = 1'b0;
      push_c    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bit_stb) begin
               word_nxt          = '0;
               word_nxt[bit_idx] = rdata_s2;
               cnt_nxt           = CW'(1);
               idle_nxt          = '0;
               state_nxt         = ST_RECV;
            end
         end
         ST_RECV: begin
            // A bit arriving in the timeout cycle takes priority over the abort.
            if (bit_stb) begin
               word_nxt[bit_idx] = rdata_s2;
               idle_nxt          = '0;
               if (bit_cnt == CW'(WIDTH - 1)) begin
                  push_c    = 1'b1;
                  cnt_nxt   = '0;
                  state_nxt = ST_IDLE;
               end else begin
                  cnt_nxt = bit_cnt + CW'(1);
               end
            end else if (idle_cnt == IW'(TIMEOUT - 1)) begin
               ferr_nxt  = 1'b1;
               cnt_nxt   = '0;
               idle_nxt  = '0;
               state_nxt = ST_IDLE;
            end else if (idle_cnt != '1) begin
               idle_nxt = idle_cnt + IW'(1);
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            idle_nxt  = '0;
         end
      endcase
   end

   // Sticky overflow: a finished word met a full FIFO with no pop to make room.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         OVERFLOW <= 1'b0;
      end else if (push_c && fifo_full && !(OUT_READY && !fifo_empty)) begin
         OVERFLOW <= 1'b1;
      end
   end

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (CLK),
      .reset     (RESET),
      .push      (push_c),
      .push_data (word_nxt),
      .pop       (OUT_READY),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .valid     (OUT_VALID),
      .level     (LEVEL),
      .head      (OUT_DATA)
   );

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: LSB-first and MSB-first receivers driven by one serial stream,
// checked every cycle against a queue-based reference plus directed scenarios.
module tb_serial_frame_rx;

   localparam int unsigned W  = 8;
   localparam int unsigned D  = 4;
   localparam int unsigned TO = 16;
   localparam int unsigned LW = $clog2(D + 1);

   logic          CLK = 1'b0;
   logic          RESET;
   logic          RCLK;
   logic          RDATA;
   logic          OUT_READY;
   logic [W-1:0]  data_l, data_m;
   logic          valid_l, valid_m;
   logic [LW-1:0] level_l, level_m;
   logic          ferr_l, ferr_m;
   logic          ovf_l, ovf_m;

   serial_frame_rx #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO), .MSB_FIRST(0)) dut_lsb (
      .CLK(CLK), .RESET(RESET), .RCLK(RCLK), .RDATA(RDATA),
      .OUT_DATA(data_l), .OUT_VALID(valid_l), .OUT_READY(OUT_READY),
      .LEVEL(level_l), .FRAME_ERR(ferr_l), .OVERFLOW(ovf_l));

   serial_frame_rx #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO), .MSB_FIRST(1)) dut_msb (
      .CLK(CLK), .RESET(RESET), .RCLK(RCLK), .RDATA(RDATA),
      .OUT_DATA(data_m), .OUT_VALID(valid_m), .OUT_READY(OUT_READY),
      .LEVEL(level_m), .FRAME_ERR(ferr_m), .OVERFLOW(ovf_m));

   always #5 CLK = ~CLK;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] rev(input logic [W-1:0] x);
      logic [W-1:0] r;
      for (int i = 0; i < W; i++) r[i] = x[W-1-i];
      return r;
   endfunction

   // Reference: words stored in arrival order (bit i = i-th received bit).
   logic [W-1:0] m_q[$];
   bit           m_bits[$];
   int           m_idle;
   bit           m_ferr, m_ovf;
   bit           h1, h2, h3, d1, d2;

   always @(posedge CLK) begin
      if (RESET) begin
         m_q.delete();
         m_bits.delete();
         m_idle = 0;
         m_ferr = 0;
         m_ovf  = 0;
         h1 = 0; h2 = 0; h3 = 0; d1 = 0; d2 = 0;
      end else begin
         bit stb, full, pop, push;
         logic [W-1:0] w;
         w    = '0;
         stb  = h2 && !h3;
         full = (m_q.size() == D);
         pop  = (m_q.size() != 0) && OUT_READY;
         push = 0;
         m_ferr = 0;
         if (stb) begin
            m_bits.push_back(d2);
            m_idle = 0;
            if (m_bits.size() == W) begin
               for (int i = 0; i < W; i++) w[i] = m_bits[i];
               push = 1;
               m_bits.delete();
            end
         end else if (m_bits.size() != 0) begin
            if (m_idle == TO - 1) begin
               m_bits.delete();
               m_idle = 0;
               m_ferr = 1;
            end else begin
               m_idle++;
            end
         end
         if (pop) void'(m_q.pop_front());
         if (push) begin
            if (!full || pop) m_q.push_back(w);
            else m_ovf = 1;
         end
         h3 = h2; h2 = h1; h1 = RCLK;
         d2 = d1; d1 = RDATA;
      end
   end

   // Cycle-by-cycle comparison against the reference.
   bit chk_en = 0;
   always @(negedge CLK) begin
      if (chk_en) begin
         check_eq("valid_l", 32'(valid_l), 32'(m_q.size() != 0));
         check_eq("valid_m", 32'(valid_m), 32'(m_q.size() != 0));
         check_eq("level_l", 32'(level_l), 32'(m_q.size()));
         check_eq("level_m", 32'(level_m), 32'(m_q.size()));
         check_eq("ferr_l", 32'(ferr_l), 32'(m_ferr));
         check_eq("ferr_m", 32'(ferr_m), 32'(m_ferr));
         check_eq("ovf_l", 32'(ovf_l), 32'(m_ovf));
         check_eq("ovf_m", 32'(ovf_m), 32'(m_ovf));
         if (m_q.size() != 0) begin
            check_eq("data_l", 32'(data_l), 32'(m_q[0]));
            check_eq("data_m", 32'(data_m), 32'(rev(m_q[0])));
         end
      end
   end

   // Observation of what the consumer actually receives.
   logic [W-1:0] got_l[$], got_m[$];
   int vcnt, fcnt, lmax;
   always @(negedge CLK) begin
      if (valid_l && OUT_READY) got_l.push_back(data_l);
      if (valid_m && OUT_READY) got_m.push_back(data_m);
      if (valid_l) vcnt++;
      if (ferr_l) fcnt++;
      if (int'(level_l) > lmax) lmax = int'(level_l);
   end

   bit rnd_rdy = 0;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
         if (rnd_rdy) OUT_READY = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic send_bit(input bit b, input int hi, input int lo);
      RDATA = b;
      RCLK  = 1'b1;
      tick(hi);
      RCLK  = 1'b0;
      tick(lo);
   endtask

   task automatic send_word(input logic [W-1:0] w, input int hi, input int lo);
      for (int i = 0; i < W; i++) send_bit(w[i], hi, lo);
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      tick(2);
      RESET = 1'b0;
      tick(3);
   endtask

   task automatic clear_mon();
      got_l.delete();
      got_m.delete();
      vcnt = 0;
      fcnt = 0;
      lmax = 0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] w;
      RESET = 1'b1; RCLK = 1'b0; RDATA = 1'b0; OUT_READY = 1'b0;
      tick(1);
      chk_en = 1;
      tick(2);
      check_eq("rst_level", 32'(level_l), 0);
      check_eq("rst_valid", 32'(valid_l), 0);
      check_eq("rst_data", 32'(data_l), 0);
      check_eq("rst_ferr", 32'(ferr_l), 0);
      check_eq("rst_ovf", 32'(ovf_l), 0);
      RESET = 1'b0;
      tick(3);

      // 0xA5 then 0x01 with the consumer always ready.
      clear_mon();
      OUT_READY = 1'b1;
      send_word(8'hA5, 2, 2);
      tick(4);
      check_eq("a5_count", 32'(got_l.size()), 1);
      if (got_l.size() == 1) check_eq("a5_lsb", 32'(got_l[0]), 32'h0A5);
      if (got_m.size() == 1) check_eq("a5_msb", 32'(got_m[0]), 32'h0A5);
      check_eq("a5_vcycles", 32'(vcnt), 1);
      check_eq("a5_lmax", 32'(lmax), 1);
      check_eq("a5_level", 32'(level_l), 0);
      clear_mon();
      send_word(8'h01, 2, 2);
      tick(4);
      if (got_m.size() == 1) check_eq("msb_rev", 32'(got_m[0]), 32'h080);
      else check_eq("msb_count", 32'(got_m.size()), 1);

      // Partial word abandoned after silence, then a clean word.
      clear_mon();
      send_bit(1'b1, 2, 2);
      send_bit(1'b0, 2, 2);
      send_bit(1'b1, 2, 2);
      tick(40);
      check_eq("to_ferr", 32'(fcnt), 1);
      check_eq("to_nopush", 32'(got_l.size()), 0);
      send_word(8'h3C, 2, 2);
      tick(4);
      check_eq("to_count", 32'(got_l.size()), 1);
      if (got_l.size() == 1) check_eq("to_word", 32'(got_l[0]), 32'h03C);
      check_eq("to_ferr2", 32'(fcnt), 1);

      // Five words into a four-entry FIFO with no consumer.
      clear_mon();
      OUT_READY = 1'b0;
      for (int k = 1; k <= 5; k++) send_word(W'(k), 2, 2);
      tick(4);
      check_eq("of_level", 32'(level_l), 4);
      check_eq("of_flag", 32'(ovf_l), 1);
      OUT_READY = 1'b1;
      tick(6);
      OUT_READY = 1'b0;
      check_eq("of_drain_n", 32'(got_l.size()), 4);
      for (int k = 0; k < 4; k++)
         if (k < got_l.size()) check_eq("of_drain", 32'(got_l[k]), 32'(k + 1));
      check_eq("of_sticky", 32'(ovf_l), 1);

      // Final bit lands in the same cycle as a pop from a full FIFO.
      do_reset();
      clear_mon();
      check_eq("fp_ovf0", 32'(ovf_l), 0);
      for (int k = 0; k < 4; k++) send_word(W'(8'h11 + k), 2, 2);
      tick(4);
      check_eq("fp_full", 32'(level_l), 4);
      w = 8'h15;
      for (int i = 0; i < W - 1; i++) send_bit(w[i], 2, 2);
      RDATA = w[W-1];
      RCLK  = 1'b1;
      tick(2);
      OUT_READY = 1'b1;
      tick(1);
      OUT_READY = 1'b0;
      RCLK = 1'b0;
      tick(2);
      check_eq("fp_level", 32'(level_l), 4);
      check_eq("fp_ovf", 32'(ovf_l), 0);
      OUT_READY = 1'b1;
      tick(6);
      check_eq("fp_n", 32'(got_l.size()), 5);
      for (int k = 0; k < 5; k++)
         if (k < got_l.size()) check_eq("fp_word", 32'(got_l[k]), 32'(8'h11 + k));

      // Reset in the middle of a word.
      clear_mon();
      for (int i = 0; i < 5; i++) send_bit(1'(i), 2, 2);
      RESET = 1'b1;
      tick(1);
      RESET = 1'b0;
      tick(3);
      send_word(8'h5A, 2, 2);
      tick(30);
      check_eq("mr_ferr", 32'(fcnt), 0);
      check_eq("mr_count", 32'(got_l.size()), 1);
      if (got_l.size() == 1) check_eq("mr_word", 32'(got_l[0]), 32'h05A);

      // Random traffic: full words, partial words with varied silence, random consumer.
      rnd_rdy = 1;
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 4) == 0) begin
            int k;
            k = $urandom_range(1, W - 1);
            for (int i = 0; i < k; i++) send_bit(1'($urandom_range(0, 1)), 1, 1);
            tick($urandom_range(10, 20));
         end else begin
            send_word(W'($urandom), $urandom_range(1, 3), $urandom_range(1, 3));
            tick($urandom_range(0, 6));
         end
      end
      rnd_rdy = 0;
      OUT_READY = 1'b1;
      tick(40);
      check_eq("end_level", 32'(level_l), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
